byte_serial_adder_ctrl: RTL and testbench
=========================================

BYTE_SERIAL_ADDER_CTRL -- requirements
Module: byte_serial_adder_ctrl

Interface
REQ-001 SHALL have parameter: NBYTES, default 4, operand width in bytes; legal range 1..16.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  operand request valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept an operand request.
REQ-006 SHALL have port: a  input  8*NBYTES  operand A.
REQ-007 SHALL have port: b  input  8*NBYTES  operand B.
REQ-008 SHALL have port: sub  input  1  0 = A+B, 1 = A-B.
REQ-009 SHALL have port: out_valid  output  1  result valid.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port: sum  output  8*NBYTES  result.
REQ-012 SHALL have port: cout  output  1  final carry out (for sub: 1 = no borrow).
REQ-013 SHALL have port: ovf  output  1  two's-complement signed overflow.
REQ-014 SHALL have port: busy  output  1  high in RUN or DONE.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-016 in_ready SHALL be 1 exactly when state is IDLE (combinational from state only).
REQ-017 In IDLE, on in_valid=1, SHALL register a, b_eff (b when sub=0, ~b when sub=1) and sub; set carry register = sub; set byte index = 0; go to RUN.
REQ-018 In RUN, each cycle SHALL add byte[idx] of A and b_eff with cin = carry register through one 8-bit adder instance, store the 8-bit result in sum byte[idx], load carry register with the adder carry out, and increment idx.
REQ-019 When idx = NBYTES-1 in RUN, SHALL capture the final carry into cout, set ovf = (A msb == b_eff msb) AND (result msb != A msb), and go to DONE; idx SHALL NOT wrap past NBYTES-1.
REQ-020 out_valid SHALL rise exactly NBYTES rising edges after the accepting edge and SHALL be 1 only in DONE.
REQ-021 In DONE, sum, cout and ovf SHALL hold stable until out_ready=1; on out_valid AND out_ready SHALL return to IDLE on that edge.
REQ-022 in_valid, a, b and sub SHALL be ignored outside IDLE; no operand is queued.
REQ-023 Sustained throughput SHALL be one operation per NBYTES+2 cycles with out_ready held high.
REQ-024 NBYTES=1 SHALL work: a single RUN cycle, then DONE.
REQ-025 sum, cout and ovf SHALL keep the last result after return to IDLE until the next RUN overwrites them.

Reset
REQ-026 rst=1 at a clock edge SHALL force state IDLE, idx 0, carry 0, sum 0, cout 0, ovf 0, out_valid 0 and busy 0, in_ready 1 on the next cycle.
REQ-027 rst asserted during RUN or DONE SHALL discard the in-flight operation with no partial result visible.
REQ-028 rst SHALL take priority over every handshake in the same cycle.

Structure
REQ-029 The FSM state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the byte width constant 8 SHALL live in shared package adder_ctrl_pkg.
REQ-030 The 8-bit add SHALL be exactly one instance of the existing ksa_8bit module, reused each cycle; no other adder logic SHALL be inferred in the carry path.

Verification (NBYTES=4)
REQ-031 Add 0x000000FF + 0x00000001, sub=0 -> sum=0x00000100, cout=0, ovf=0, out_valid 4 edges after accept.
REQ-032 Add 0xFFFFFFFF + 0x00000001 -> sum=0x00000000, cout=1, ovf=0.
REQ-033 Sub 0x80000000 - 0x00000001 -> sum=0x7FFFFFFF, cout=1, ovf=1; add 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, cout=0, ovf=1.
REQ-034 Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands -> out_valid stays 1, sum stays stable, in_ready stays 0, the new operands are dropped.
REQ-035 Assert rst for 1 cycle at idx=2 of RUN -> next cycle IDLE, in_ready=1, out_valid=0, sum=0; a following 0x12345678 + 0x11111111 gives 0x23456789.
REQ-036 Run 1000 random back-to-back ops with out_ready=1, both sub values -> every result matches the reference model, with 6 cycles per op.

Source files
------------

// File: rtl/adder_ctrl_pkg.sv
// Shared definitions for the byte-serial adder controller: FSM encoding and
// datapath byte width.
package adder_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Byte index width; at least one bit so NBYTES=1 still has a legal vector.
  function automatic int idx_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/ksa_8bit.sv
// 8-bit Kogge-Stone adder with carry in; the only adder in the serial carry
// path, reused once per byte by the controller.
module ksa_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  logic [7:0] p;
  logic [7:0] g0;
  logic [7:0] g1;
  logic [7:0] p1;
  logic [7:0] g2;
  logic [7:4] p2;
  logic [7:0] g3;

  always_comb begin
    p  = a ^ b;
    g0 = a & b;
    // Fold cin into bit 0 so every prefix carries the external carry.
    g0[0] = g0[0] | (p[0] & cin);

    for (int i = 0; i < 1; i++) begin
      g1[i] = g0[i];
      p1[i] = p[i];
    end
    for (int i = 1; i < 8; i++) begin
      g1[i] = g0[i] | (p[i] & g0[i-1]);
      p1[i] = p[i] & p[i-1];
    end

    for (int i = 0; i < 2; i++) g2[i] = g1[i];
    for (int i = 2; i < 8; i++) g2[i] = g1[i] | (p1[i] & g1[i-2]);
    for (int i = 4; i < 8; i++) p2[i] = p1[i] & p1[i-2];

    for (int i = 0; i < 4; i++) g3[i] = g2[i];
    for (int i = 4; i < 8; i++) g3[i] = g2[i] | (p2[i] & g2[i-4]);

    s    = p ^ {g3[6:0], cin};
    cout = g3[7];
  end

endmodule

// File: rtl/byte_serial_adder_ctrl.sv
// Byte-serial add/subtract controller: accepts an operand pair, walks it one
// byte per cycle through a single 8-bit adder, then holds the result for the consumer.
//
// state | meaning
// IDLE  | ready for an operand request; last result still visible
// RUN   | one byte per cycle through the adder, LSB first
// DONE  | result valid, held until out_ready
module byte_serial_adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     cout,
  output logic                     ovf,
  output logic                     busy
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = idx_width(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t             state_q;
  state_t             state_d;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic [W-1:0]       sum_q;
  logic               cout_q;
  logic               ovf_q;
  logic               accept;
  logic               last_byte;
  logic [BYTE_W-1:0]  a_byte;
  logic [BYTE_W-1:0]  b_byte;
  logic [BYTE_W-1:0]  add_s;
  logic               add_co;

  assign last_byte = (idx_q == LAST_IDX);
  assign a_byte    = a_q[BYTE_W*int'(idx_q) +: BYTE_W];
  assign b_byte    = b_q[BYTE_W*int'(idx_q) +: BYTE_W];

  ksa_8bit u_ksa (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_byte) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1: invert B here and seed the carry with sub.
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub;
      idx_q   <= '0;
    end else if (state_q == ST_RUN) begin
      sum_q[BYTE_W*int'(idx_q) +: BYTE_W] <= add_s;
      carry_q <= add_co;
      if (last_byte) begin
        cout_q <= add_co;
        ovf_q  <= (a_q[W-1] == b_q[W-1]) && (add_s[BYTE_W-1] != a_q[W-1]);
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_byte_serial_adder_ctrl.sv
// Bench for byte_serial_adder_ctrl (NBYTES=4): directed vector table, handshake
// and reset corner sequences, then random back-to-back ops against an arithmetic model.
module tb_byte_serial_adder_ctrl;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         sub_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int acc_cyc;

  byte_serial_adder_ctrl #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .sub       (sub_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the whole operands.
  task automatic ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rs,
                           output logic [W-1:0] es, output logic ec, output logic eo);
    logic [W:0] t;
    if (!rs) begin
      t  = {1'b0, ra} + {1'b0, rb};
      es = t[W-1:0];
      ec = t[W];
      eo = (ra[W-1] == rb[W-1]) && (es[W-1] != ra[W-1]);
    end else begin
      es = ra - rb;
      ec = (ra >= rb);
      eo = (ra[W-1] != rb[W-1]) && (es[W-1] != ra[W-1]);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
  task automatic accept_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic os,
                           input bit hold_valid);
    wait_ready();
    a_i = oa; b_i = ob; sub_i = os; in_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (!hold_valid) in_valid = 1'b0;
    a_i = $urandom; b_i = $urandom; sub_i = 1'($urandom);
  endtask

  // Counts edges from accept until out_valid; scrambles inputs meanwhile.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!out_valid) begin
        chk("busy_in_run", {busy, in_ready}, 2'b10);
        a_i = $urandom; b_i = $urandom; sub_i = 1'($urandom);
      end
    end while (!out_valid && lat < 50);
    chk("out_valid_wait", out_valid, 1);
  endtask

  initial begin
    int           lat;
    int           prev_acc;
    logic [W-1:0] keep;
    logic [W-1:0] ra, rb, es;
    logic         rs, ec, eo;

    tbl[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[4] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    tbl[6] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[7] = '{32'h1234_5678, 32'h1234_5679, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; a_i = '0; b_i = '0; sub_i = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout_ovf", {cout, ovf}, 2'b00);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      accept_op(tbl[i].a, tbl[i].b, tbl[i].sub, 1'b0);
      wait_done(lat);
      chk("tbl_latency", lat, NB);
      chk("tbl_sum", sum, tbl[i].sum);
      chk("tbl_cout", cout, tbl[i].cout);
      chk("tbl_ovf", ovf, tbl[i].ovf);
      @(posedge clk); #1;
      chk("tbl_back_idle", {in_ready, out_valid, busy}, 3'b100);
      chk("tbl_sum_kept", sum, tbl[i].sum);
    end

    // Consumer stalls in DONE while new requests arrive
    out_ready = 1'b0;
    accept_op(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    wait_done(lat);
    keep = sum;
    chk("stall_sum", keep, 32'h3333_3333);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a_i = $urandom; b_i = $urandom; sub_i = 1'($urandom);
      @(posedge clk); #1;
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_sum_stable", sum, keep);
      chk("stall_flags", {cout, ovf}, 2'b00);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", {in_ready, out_valid, busy}, 3'b100);
    chk("stall_sum_after", sum, keep);
    @(posedge clk); #1;
    chk("stall_dropped", busy, 0);

    // Reset in the middle of RUN (idx=2)
    accept_op(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_state", {in_ready, out_valid, busy}, 3'b100);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_flags", {cout, ovf}, 2'b00);
    accept_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    wait_done(lat);
    chk("post_rst_latency", lat, NB);
    chk("post_rst_sum", sum, 32'h2345_6789);
    chk("post_rst_flags", {cout, ovf}, 2'b00);
    @(posedge clk); #1;

    // Random back-to-back traffic with in_valid held high
    prev_acc = 0;
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 7))
        0:       begin ra = 32'h8000_0000; rb = $urandom; end
        1:       begin ra = 32'h7FFF_FFFF; rb = $urandom; end
        2:       begin ra = $urandom;      rb = ra;       end
        default: begin ra = $urandom;      rb = $urandom; end
      endcase
      rs = 1'($urandom);
      ref_model(ra, rb, rs, es, ec, eo);
      accept_op(ra, rb, rs, 1'b1);
      if (i > 0) chk("rnd_throughput", acc_cyc - prev_acc, NB + 2);
      prev_acc = acc_cyc;
      wait_done(lat);
      chk("rnd_latency", lat, NB);
      chk("rnd_sum", sum, es);
      chk("rnd_cout", cout, ec);
      chk("rnd_ovf", ovf, eo);
    end
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
